idu_jump_swc: RTL and testbench

Decode-and-sequence stage feeding the jump execution unit of the switch-controlled core. Accepts one fetched instruction per handshake and decodes JAL/JALR into the `dec_*` fields and immediates. Holds them stable while driving the `cycle_cnt` counter that paces the jump EXU. Consumes the EXU's `flush` request to discard speculatively fetched instructions.

---
 rtl/swc_pkg.sv | 15 +
 rtl/idu_imm_gen.sv | 20 ++
 rtl/idu_jump_swc.sv | 120 ++++++++++++
 tb/tb_idu_jump_swc.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/swc_pkg.sv
// rtl/swc_pkg.sv - shared opcode constants, state type and defaults for the switch-controlled core
package swc_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [2:0] F3_JALR  = 3'b000;

  localparam int JUMP_CYCLES_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } idu_state_t;

endpackage

// File: rtl/idu_imm_gen.sv
// rtl/idu_imm_gen.sv - combinational field and I/J immediate extraction from an instruction word
module idu_imm_gen (
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [11:0] imm_i,
  output logic [20:0] imm_j
);

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign imm_i  = instr[31:20];
  // J-type offset is always even, so bit 0 is a constant zero
  assign imm_j  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/idu_jump_swc.sv
// rtl/idu_jump_swc.sv - JAL/JALR decode stage that paces the jump EXU and honours EXU flush requests
module idu_jump_swc
  import swc_pkg::*;
#(
  parameter int JUMP_CYCLES = JUMP_CYCLES_DEF
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  output logic        instr_ready,
  input  logic [1:0]  flush,
  output logic [3:0]  cycle_cnt,
  output logic        dec_jump_en,
  output logic        dec_jal,
  output logic        dec_jalr,
  output logic        dec_other,
  output logic [11:0] dec_imm_type_i,
  output logic [20:0] dec_imm_type_j,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [31:0] pc,
  output logic        dec_illegal
);

  localparam logic [3:0] JUMP_LAST = 4'(JUMP_CYCLES - 1);

  idu_state_t  state;
  logic [1:0]  drop_cnt;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [11:0] imm_i;
  logic [20:0] imm_j;

  logic        xfer;
  logic        keep;
  logic        is_jal;
  logic        is_jalr_op;
  logic [3:0]  last_cnt;

  idu_imm_gen u_imm_gen (
    .instr  (instr),
    .opcode (opcode),
    .funct3 (funct3),
    .rd     (rd),
    .rs1    (rs1),
    .imm_i  (imm_i),
    .imm_j  (imm_j)
  );

  assign instr_ready = (state == IDLE) && !hrst;
  assign xfer        = instr_valid && instr_ready;
  // a flush on the transfer edge already claims this instruction as the first drop
  assign keep        = xfer && (flush == 2'd0) && (drop_cnt == 2'd0);
  assign is_jal      = (opcode == OPC_JAL);
  assign is_jalr_op  = (opcode == OPC_JALR);
  assign last_cnt    = dec_other ? 4'd0 : JUMP_LAST;

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state          <= IDLE;
      drop_cnt       <= 2'd0;
      cycle_cnt      <= 4'd0;
      dec_jump_en    <= 1'b0;
      dec_jal        <= 1'b0;
      dec_jalr       <= 1'b0;
      dec_other      <= 1'b0;
      dec_imm_type_i <= 12'd0;
      dec_imm_type_j <= 21'd0;
      dec_rd         <= 5'd0;
      dec_rs1        <= 5'd0;
      pc             <= 32'd0;
      dec_illegal    <= 1'b0;
    end else begin
      dec_illegal <= 1'b0;

      if (flush != 2'd0) begin
        drop_cnt <= xfer ? (flush - 2'd1) : flush;
      end else if (xfer && (drop_cnt != 2'd0)) begin
        drop_cnt <= drop_cnt - 2'd1;
      end

      if (state == IDLE) begin
        if (keep) begin
          if (is_jalr_op && (funct3 != F3_JALR)) begin
            dec_illegal <= 1'b1;
          end else begin
            state          <= EXEC;
            cycle_cnt      <= 4'd0;
            dec_jal        <= is_jal;
            dec_jalr       <= is_jalr_op;
            dec_jump_en    <= is_jal || is_jalr_op;
            dec_other      <= !(is_jal || is_jalr_op);
            dec_imm_type_i <= imm_i;
            dec_imm_type_j <= imm_j;
            dec_rd         <= rd;
            dec_rs1        <= rs1;
            pc             <= instr_pc;
          end
        end
      end else begin
        if (cycle_cnt == last_cnt) begin
          state       <= IDLE;
          cycle_cnt   <= 4'd0;
          dec_jump_en <= 1'b0;
          dec_jal     <= 1'b0;
          dec_jalr    <= 1'b0;
          dec_other   <= 1'b0;
        end else begin
          cycle_cnt <= cycle_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_idu_jump_swc.sv
// tb/tb_idu_jump_swc.sv - directed plus randomized bench for idu_jump_swc against a transaction-level model
module tb_idu_jump_swc;

  localparam int JC = 3;

  logic        hclk;
  logic        hrst;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [1:0]  flush;
  logic [3:0]  cycle_cnt;
  logic        dec_jump_en;
  logic        dec_jal;
  logic        dec_jalr;
  logic        dec_other;
  logic [11:0] dec_imm_type_i;
  logic [20:0] dec_imm_type_j;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [31:0] pc;
  logic        dec_illegal;

  int checks = 0;
  int errors = 0;
  int drop   = 0;

  idu_jump_swc #(.JUMP_CYCLES(JC)) dut (
    .hclk           (hclk),
    .hrst           (hrst),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .flush          (flush),
    .cycle_cnt      (cycle_cnt),
    .dec_jump_en    (dec_jump_en),
    .dec_jal        (dec_jal),
    .dec_jalr       (dec_jalr),
    .dec_other      (dec_other),
    .dec_imm_type_i (dec_imm_type_i),
    .dec_imm_type_j (dec_imm_type_j),
    .dec_rd         (dec_rd),
    .dec_rs1        (dec_rs1),
    .pc             (pc),
    .dec_illegal    (dec_illegal)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 0=JAL 1=JALR 2=illegal JALR 3=other
  function automatic int classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    if (op == 7'h6F) return 0;
    if (op == 7'h67) return (f3 == 3'd0) ? 1 : 2;
    return 3;
  endfunction

  function automatic logic [20:0] jimm(input logic [31:0] w);
    logic [20:0] v;
    v = '0;
    v[20]    = w[31];
    v[19:12] = w[19:12];
    v[11]    = w[20];
    v[10:1]  = w[30:21];
    return v;
  endfunction

  task automatic chk_idle_flags(input string tag);
    chk({tag, "_rdy"}, instr_ready, 1);
    chk({tag, "_jump_en"}, dec_jump_en, 0);
    chk({tag, "_jal"}, dec_jal, 0);
    chk({tag, "_jalr"}, dec_jalr, 0);
    chk({tag, "_other"}, dec_other, 0);
    chk({tag, "_cnt"}, cycle_cnt, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, instr_ready, 0);
    chk({tag, "_flags"}, {dec_jump_en, dec_jal, dec_jalr, dec_other, dec_illegal}, 0);
    chk({tag, "_cnt"}, cycle_cnt, 0);
    chk({tag, "_imm_i"}, dec_imm_type_i, 0);
    chk({tag, "_imm_j"}, dec_imm_type_j, 0);
    chk({tag, "_rd_rs1"}, {dec_rd, dec_rs1}, 0);
    chk({tag, "_pc"}, pc, 0);
  endtask

  // Offer one instruction for one edge; optionally raise flush during its execution.
  task automatic do_xfer(input logic [31:0] w, input logic [31:0] ipc, input logic [1:0] fl,
                         input logic [1:0] exec_fl, input int exec_fl_at);
    int kind;
    int len;
    bit dropped;
    chk("pre_rdy", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = w;
    instr_pc    = ipc;
    flush       = fl;
    tick();
    instr_valid = 1'b0;
    flush       = 2'd0;
    instr       = $urandom;
    instr_pc    = $urandom;
    dropped = 1'b0;
    if (fl != 0) begin
      drop = int'(fl) - 1;
      dropped = 1'b1;
    end else if (drop > 0) begin
      drop--;
      dropped = 1'b1;
    end
    if (dropped) begin
      chk_idle_flags("drop");
      chk("drop_ill", dec_illegal, 0);
      return;
    end
    kind = classify(w);
    if (kind == 2) begin
      chk("ill_pulse", dec_illegal, 1);
      chk_idle_flags("ill");
      tick();
      chk("ill_clear", dec_illegal, 0);
      chk("ill_rdy2", instr_ready, 1);
      return;
    end
    len = (kind == 3) ? 1 : JC;
    for (int k = 0; k < len; k++) begin
      chk("ex_rdy", instr_ready, 0);
      chk("ex_cnt", cycle_cnt, k);
      chk("ex_jal", dec_jal, kind == 0);
      chk("ex_jalr", dec_jalr, kind == 1);
      chk("ex_jump_en", dec_jump_en, kind < 2);
      chk("ex_other", dec_other, kind == 3);
      chk("ex_imm_i", dec_imm_type_i, w[31:20]);
      chk("ex_imm_j", dec_imm_type_j, jimm(w));
      chk("ex_rd", dec_rd, w[11:7]);
      chk("ex_rs1", dec_rs1, w[19:15]);
      chk("ex_pc", pc, ipc);
      chk("ex_ill", dec_illegal, 0);
      if (k == exec_fl_at && exec_fl != 0) begin
        flush = exec_fl;
        drop  = int'(exec_fl);
      end
      tick();
      flush = 2'd0;
    end
    chk_idle_flags("post");
    chk("post_pc", pc, ipc);
    chk("post_rd", dec_rd, w[11:7]);
  endtask

  initial begin
    logic [31:0] w;
    logic [1:0]  fl;
    logic [1:0]  efl;
    hrst        = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    instr_pc    = 32'd0;
    flush       = 2'd0;

    repeat (3) tick();
    chk_all_zero("rst");
    hrst = 1'b0;
    #1;
    chk("rst_release_rdy", instr_ready, 1);
    drop = 0;

    do_xfer(32'h008000EF, 32'h100, 2'd0, 2'd0, -1);
    chk("jal_imm_j", dec_imm_type_j, 21'h000008);
    chk("jal_rd", dec_rd, 1);
    chk("jal_pc", pc, 32'h100);

    do_xfer(32'h00C28067, 32'h140, 2'd0, 2'd0, -1);
    chk("jalr_rs1", dec_rs1, 5);
    chk("jalr_rd", dec_rd, 0);
    chk("jalr_imm_i", dec_imm_type_i, 12'h00C);
    do_xfer(32'h00C29067, 32'h144, 2'd0, 2'd0, -1);
    chk("ill_pc_kept", pc, 32'h140);

    do_xfer(32'h008000EF, 32'h200, 2'd0, 2'd2, 1);
    do_xfer(32'h00100093, 32'h204, 2'd0, 2'd0, -1);
    do_xfer(32'h00100093, 32'h208, 2'd0, 2'd0, -1);
    do_xfer(32'h00C28067, 32'h20C, 2'd0, 2'd0, -1);
    chk("flush_exec_pc", pc, 32'h20C);

    do_xfer(32'h008000EF, 32'h300, 2'd1, 2'd0, -1);
    chk("flush_edge_pc_kept", pc, 32'h20C);
    do_xfer(32'h00100093, 32'h304, 2'd0, 2'd0, -1);
    chk("flush_edge_next_pc", pc, 32'h304);

    instr_valid = 1'b1;
    instr       = 32'h008000EF;
    instr_pc    = 32'h400;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("mid_cnt", cycle_cnt, 1);
    hrst = 1'b1;
    tick();
    chk_all_zero("mid_rst");
    hrst = 1'b0;
    #1;
    chk("mid_release_rdy", instr_ready, 1);
    drop = 0;
    do_xfer(32'h00100093, 32'h500, 2'd0, 2'd0, -1);

    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      case ($urandom_range(0, 4))
        0: w[6:0] = 7'h6F;
        1: begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
        2: begin w[6:0] = 7'h67; w[14:12] = 3'($urandom_range(1, 7)); end
        default: if (w[6:0] == 7'h6F || w[6:0] == 7'h67) w[0] = ~w[0];
      endcase
      fl  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      efl = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      do_xfer(w, $urandom, fl, efl, $urandom_range(0, JC - 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
